// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit path: channel tags, default
// geometry and the link sequencing states used by the bit-clock generator.
package i2s_pkg;

   localparam logic TAG_LEFT  = 1'b1;
   localparam logic TAG_RIGHT = 1'b0;

   localparam int DEF_DATA_W   = 24;
   localparam int DEF_SLOT_W   = 32;
   localparam int DEF_BCLK_DIV = 4;

   typedef enum logic [1:0] {
      LINK_IDLE = 2'd0,
      LINK_ARM  = 2'd1,
      LINK_RUN  = 2'd2
   } link_state_e;

   // Index width able to address n positions, never less than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Master bit-clock generator: divides clk into BCLK, counts bit positions in
// the stereo frame, drives word select and flags the frame-load fall edges.
module i2s_tx_clkgen
   import i2s_pkg::*;
#(
   parameter int  SLOT_W   = DEF_SLOT_W,
   parameter int  BCLK_DIV = DEF_BCLK_DIV,
   localparam int BCNT_W   = idx_w(2 * SLOT_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   output logic              bclk_o,
   output logic              lrck_o,
   output logic              fall_stb_o,
   output logic              frame_stb_o,
   output logic [BCNT_W-1:0] bit_nxt_o
);

   localparam int                DIV_W      = idx_w(BCLK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_DIV - 1);
   localparam logic [BCNT_W-1:0] BIT_LAST   = BCNT_W'(2 * SLOT_W - 1);
   localparam logic [BCNT_W-1:0] SLOT_FIRST = BCNT_W'(SLOT_W);

   link_state_e       state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic              bclk_q, bclk_d;
   logic              lrck_q, lrck_d;
   logic              toggle;
   logic              fall_stb;
   logic [BCNT_W-1:0] bit_inc;

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      toggle    = en_i && (div_cnt_q == DIV_LAST);
      fall_stb  = toggle && bclk_q;
      bit_inc   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BCNT_W'(1);
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      bclk_d    = bclk_q;
      bit_cnt_d = bit_cnt_q;
      lrck_d    = lrck_q;

      if (!en_i) begin
         state_d   = LINK_IDLE;
         div_cnt_d = '0;
         bclk_d    = 1'b0;
         bit_cnt_d = '0;
         lrck_d    = 1'b0;
      end else begin
         div_cnt_d = toggle ? '0 : div_cnt_q + DIV_W'(1);
         if (toggle) begin
            bclk_d = ~bclk_q;
         end
         if (fall_stb) begin
            bit_cnt_d = bit_inc;
            lrck_d    = (bit_inc >= SLOT_FIRST);
         end
         unique case (state_q)
            LINK_IDLE: state_d = LINK_ARM;
            LINK_ARM:  if (fall_stb) state_d = LINK_RUN;
            LINK_RUN:  state_d = LINK_RUN;
            default:   state_d = LINK_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them
   // sample the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LINK_IDLE;
         div_cnt_q <= '0;
         bclk_q    <= 1'b0;
         bit_cnt_q <= '0;
         lrck_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
         bit_cnt_q <= bit_cnt_d;
         lrck_q    <= lrck_d;
      end
   end

   // The first fall after enabling also loads a frame, so the opening frame
   // starts at bit 0 without waiting a full wrap.
   assign bclk_o      = bclk_q;
   assign lrck_o      = lrck_q;
   assign fall_stb_o  = fall_stb;
   assign frame_stb_o = fall_stb && ((state_q == LINK_ARM) || (bit_cnt_q == BIT_LAST));
   assign bit_nxt_o   = bit_inc;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips-I2S master transmitter with one stereo frame of double buffering.
// Build option I2S_TX_HOLD_LAST_EN: repeat the last frame on underrun instead of silence.
module i2s_tx_serializer
   import i2s_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int SLOT_W   = DEF_SLOT_W,
   parameter int BCLK_DIV = DEF_BCLK_DIV
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_en,
   input  logic        lrc,
   input  logic [31:0] data_in,
   input  logic        data_valid,
   output logic        i2s_bclk,
   output logic        i2s_lrck,
   output logic        i2s_sdata,
   output logic        underrun,
   output logic        overflow
);

   localparam int BCNT_W = idx_w(2 * SLOT_W);
   localparam int SIDX_W = idx_w(SLOT_W);

   logic              fall_stb;
   logic              frame_stb;
   logic [BCNT_W-1:0] bit_nxt;

   i2s_tx_clkgen #(
      .SLOT_W   (SLOT_W),
      .BCLK_DIV (BCLK_DIV)
   ) u_clkgen (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (tx_en),
      .bclk_o      (i2s_bclk),
      .lrck_o      (i2s_lrck),
      .fall_stb_o  (fall_stb),
      .frame_stb_o (frame_stb),
      .bit_nxt_o   (bit_nxt)
   );

   logic [DATA_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
   logic              flag_l_q, flag_l_d, flag_r_q, flag_r_d;
   logic              sdata_q, sdata_d;
   logic              underrun_q, underrun_d;
   logic              overflow_q, overflow_d;

   logic              wr_l, wr_r, load_ok, chan_right;
   logic [SIDX_W-1:0] slot_k;
   logic [DATA_W-1:0] sample;
   logic              unused_data_hi;

   assign sample         = data_in[DATA_W-1:0];
   assign unused_data_hi = ^data_in[31:DATA_W];

   // Slot bit 0 is the I2S one-bit delay; bits 1..DATA_W carry the sample MSB first.
   function automatic logic slot_bit(input logic [DATA_W-1:0] s, input logic [SIDX_W-1:0] k);
      logic [DATA_W-1:0] sh;
      sh = s << (k - SIDX_W'(1));
      return ((k != '0) && (k <= SIDX_W'(DATA_W))) ? sh[DATA_W-1] : 1'b0;
   endfunction

   always_comb begin
      wr_l       = data_valid && (lrc == TAG_LEFT);
      wr_r       = data_valid && (lrc == TAG_RIGHT);
      load_ok    = frame_stb && flag_l_q && flag_r_q;
      chan_right = (bit_nxt >= BCNT_W'(SLOT_W));
      slot_k     = SIDX_W'(chan_right ? bit_nxt - BCNT_W'(SLOT_W) : bit_nxt);

      pend_l_d   = pend_l_q;
      pend_r_d   = pend_r_q;
      act_l_d    = act_l_q;
      act_r_d    = act_r_q;
      flag_l_d   = flag_l_q;
      flag_r_d   = flag_r_q;
      sdata_d    = sdata_q;
      underrun_d = 1'b0;
      overflow_d = 1'b0;

      if (!tx_en) begin
         pend_l_d = '0;
         pend_r_d = '0;
         act_l_d  = '0;
         act_r_d  = '0;
         flag_l_d = 1'b0;
         flag_r_d = 1'b0;
         sdata_d  = 1'b0;
      end else begin
         // A write landing on the load edge refills the slot the load just emptied.
         if (wr_l) pend_l_d = sample;
         if (wr_r) pend_r_d = sample;
         flag_l_d   = (flag_l_q && !load_ok) || wr_l;
         flag_r_d   = (flag_r_q && !load_ok) || wr_r;
         overflow_d = ((wr_l && flag_l_q) || (wr_r && flag_r_q)) && !load_ok;
         underrun_d = frame_stb && !load_ok;

         if (frame_stb) begin
            if (load_ok) begin
               act_l_d = pend_l_q;
               act_r_d = pend_r_q;
            end else begin
`ifdef I2S_TX_HOLD_LAST_EN
               act_l_d = act_l_q;
               act_r_d = act_r_q;
`else
               act_l_d = '0;
               act_r_d = '0;
`endif
            end
         end

         // Use the post-load frame so a fresh pair shows its MSB at slot bit 1.
         if (fall_stb) begin
            sdata_d = slot_bit(chan_right ? act_r_d : act_l_d, slot_k);
         end
      end
   end

   // NOTE: the sample buffers are cleared by reset as well, because an
   // aborted frame must never replay stale audio after restart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_l_q   <= '0;
         pend_r_q   <= '0;
         act_l_q    <= '0;
         act_r_q    <= '0;
         flag_l_q   <= 1'b0;
         flag_r_q   <= 1'b0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         pend_l_q   <= pend_l_d;
         pend_r_q   <= pend_r_d;
         act_l_q    <= act_l_d;
         act_r_q    <= act_r_d;
         flag_l_q   <= flag_l_d;
         flag_r_q   <= flag_r_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
      end
   end

   assign i2s_sdata = sdata_q;
   assign underrun  = underrun_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer (DATA_W=24, SLOT_W=32, BCLK_DIV=2).
// Honours I2S_TX_HOLD_LAST_EN for the underrun-frame expectation.
module tb_i2s_tx_serializer;

   localparam int BCLK_DIV = 2;
   localparam logic [63:0] LRCK_EXP = 64'hFFFF_FFFF_0000_0000;

   logic        clk = 1'b0;
   logic        rst_n, tx_en, lrc, data_valid;
   logic [31:0] data_in;
   logic        i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int und_cnt = 0;
   int ovf_cnt = 0;

   logic [63:0] sd, sd2, lr;
   int          tmo, bg;

   always #5 clk = ~clk;

   i2s_tx_serializer #(
      .DATA_W   (24),
      .SLOT_W   (32),
      .BCLK_DIV (BCLK_DIV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_en      (tx_en),
      .lrc        (lrc),
      .data_in    (data_in),
      .data_valid (data_valid),
      .i2s_bclk   (i2s_bclk),
      .i2s_lrck   (i2s_lrck),
      .i2s_sdata  (i2s_sdata),
      .underrun   (underrun),
      .overflow   (overflow)
   );

   always @(negedge clk) begin
      if (underrun === 1'b1) und_cnt++;
      if (overflow === 1'b1) ovf_cnt++;
   end

   // Expected serial frame indexed by bit position 0..63.
   function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
      logic [63:0] f;
      logic [23:0] s;
      int          k;
      f = '0;
      for (int b = 0; b < 64; b++) begin
         k = b % 32;
         s = (b < 32) ? l : r;
         if (k >= 1 && k <= 24) f[b] = s[24-k];
      end
      return f;
   endfunction

   task automatic next_fall(output bit ok, output int gap);
      logic p;
      ok  = 1'b0;
      gap = 0;
      p   = i2s_bclk;
      for (int i = 0; i < 16 && !ok; i++) begin
         @(negedge clk);
         gap++;
         if (p === 1'b1 && i2s_bclk === 1'b0) ok = 1'b1;
         p = i2s_bclk;
      end
   endtask

   task automatic capture(input int first, input int last, output logic [63:0] s_o,
                          output logic [63:0] l_o, output int t_o, output int g_o);
      bit ok;
      int gap;
      s_o = '0;
      l_o = '0;
      t_o = 0;
      g_o = 0;
      for (int b = first; b <= last; b++) begin
         next_fall(ok, gap);
         if (!ok) t_o++;
         else begin
            s_o[b] = i2s_sdata;
            l_o[b] = i2s_lrck;
            if (b != first && gap != 2 * BCLK_DIV) g_o++;
         end
      end
   endtask

   task automatic write(input logic ch, input logic [23:0] d);
      lrc        = ch;
      data_in    = {8'h00, d};
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      data_in    = '0;
      lrc        = 1'b0;
   endtask

   task automatic restart();
      tx_en = 1'b0;
      repeat (2) @(negedge clk);
      tx_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bit ok;
      int gap, u0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_hold: got %b want 00000", {i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow} !== 5'b0) begin
         n_bad++;
         $display("FAIL idle_after_reset: got %b want 00000", {i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow});
      end
      restart();
      write(1'b1, 24'hFFFFFF);
      write(1'b0, 24'hFFFFFF);
      capture(1, 45, sd, lr, tmo, bg);
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata} !== 3'b111) begin
         n_bad++;
         $display("FAIL pre_reset_mid_frame: got %b want 111", {i2s_bclk, i2s_lrck, i2s_sdata});
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow} !== 5'b0) begin
         n_bad++;
         $display("FAIL async_reset_abort: got %b want 00000", {i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow});
      end
      @(negedge clk);
      u0    = und_cnt;
      rst_n = 1'b1;
      next_fall(ok, gap);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL restart_fall_timeout: got no fall want fall");
      end
      n_cmp++;
      if ({i2s_lrck, i2s_sdata} !== 2'b00) begin
         n_bad++;
         $display("FAIL restart_bit1: got %b want 00", {i2s_lrck, i2s_sdata});
      end
      @(negedge clk);
      n_cmp++;
      if (und_cnt - u0 !== 1) begin
         n_bad++;
         $display("FAIL restart_empty_underrun: got %0d want 1", und_cnt - u0);
      end
   endtask

   task automatic test_frame();
      int u0, o0;
      restart();
      u0 = und_cnt;
      o0 = ovf_cnt;
      write(1'b1, 24'h800001);
      write(1'b0, 24'h7FFFFE);
      capture(1, 63, sd, lr, tmo, bg);
      @(negedge clk);
      n_cmp++;
      if (sd !== exp_frame(24'h800001, 24'h7FFFFE)) begin
         n_bad++;
         $display("FAIL frame_sdata: got %h want %h", sd, exp_frame(24'h800001, 24'h7FFFFE));
      end
      n_cmp++;
      if (lr !== LRCK_EXP) begin
         n_bad++;
         $display("FAIL frame_lrck: got %h want %h", lr, LRCK_EXP);
      end
      n_cmp++;
      if (tmo !== 0) begin
         n_bad++;
         $display("FAIL frame_timeout: got %0d want 0", tmo);
      end
      n_cmp++;
      if (bg !== 0) begin
         n_bad++;
         $display("FAIL bclk_period: got %0d bad gaps want 0", bg);
      end
      n_cmp++;
      if (und_cnt - u0 !== 0) begin
         n_bad++;
         $display("FAIL frame_underrun: got %0d want 0", und_cnt - u0);
      end
      n_cmp++;
      if (ovf_cnt - o0 !== 0) begin
         n_bad++;
         $display("FAIL frame_overflow: got %0d want 0", ovf_cnt - o0);
      end
   endtask

   task automatic test_underrun();
      int u0, t1;
      logic [63:0] want2;
      restart();
      write(1'b1, 24'h123456);
      write(1'b0, 24'h654321);
      capture(1, 63, sd, lr, tmo, bg);
      t1 = tmo;
      u0 = und_cnt;
      capture(0, 63, sd2, lr, tmo, bg);
      @(negedge clk);
`ifdef I2S_TX_HOLD_LAST_EN
      want2 = exp_frame(24'h123456, 24'h654321);
`else
      want2 = '0;
`endif
      n_cmp++;
      if (sd !== exp_frame(24'h123456, 24'h654321)) begin
         n_bad++;
         $display("FAIL underrun_first_frame: got %h want %h", sd, exp_frame(24'h123456, 24'h654321));
      end
      n_cmp++;
      if (sd2 !== want2) begin
         n_bad++;
         $display("FAIL underrun_frame: got %h want %h", sd2, want2);
      end
      n_cmp++;
      if (und_cnt - u0 !== 1) begin
         n_bad++;
         $display("FAIL underrun_pulse: got %0d want 1", und_cnt - u0);
      end
      n_cmp++;
      if (t1 + tmo !== 0) begin
         n_bad++;
         $display("FAIL underrun_timeout: got %0d want 0", t1 + tmo);
      end
   endtask

   task automatic test_overflow();
      int o0, t1;
      restart();
      capture(1, 10, sd, lr, tmo, bg);
      t1 = tmo;
      o0 = ovf_cnt;
      write(1'b1, 24'h000001);
      write(1'b1, 24'h000002);
      write(1'b0, 24'h000003);
      capture(11, 63, sd, lr, tmo, bg);
      t1 = t1 + tmo;
      capture(0, 63, sd, lr, tmo, bg);
      @(negedge clk);
      n_cmp++;
      if (ovf_cnt - o0 !== 1) begin
         n_bad++;
         $display("FAIL overflow_pulse: got %0d want 1", ovf_cnt - o0);
      end
      n_cmp++;
      if (sd !== exp_frame(24'h000002, 24'h000003)) begin
         n_bad++;
         $display("FAIL overflow_frame: got %h want %h", sd, exp_frame(24'h000002, 24'h000003));
      end
      n_cmp++;
      if (t1 + tmo !== 0) begin
         n_bad++;
         $display("FAIL overflow_timeout: got %0d want 0", t1 + tmo);
      end
   endtask

   task automatic test_back_to_back();
      int u0, o0, tt;
      bit ok;
      int gap;
      logic b1;
      restart();
      u0 = und_cnt;
      o0 = ovf_cnt;
      write(1'b1, 24'hA5A5A5);
      write(1'b0, 24'h0F0F0F);
      lrc        = 1'b0;
      data_in    = 32'h003C3C3C;
      data_valid = 1'b1;
      next_fall(ok, gap);
      data_valid = 1'b0;
      data_in    = '0;
      b1         = i2s_sdata;
      tt         = ok ? 0 : 1;
      capture(2, 40, sd, lr, tmo, bg);
      tt = tt + tmo;
      sd[1] = b1;
      write(1'b1, 24'hC00003);
      capture(41, 63, sd2, lr, tmo, bg);
      tt = tt + tmo;
      sd = sd | sd2;
      n_cmp++;
      if (sd !== exp_frame(24'hA5A5A5, 24'h0F0F0F)) begin
         n_bad++;
         $display("FAIL b2b_old_pair: got %h want %h", sd, exp_frame(24'hA5A5A5, 24'h0F0F0F));
      end
      capture(0, 63, sd, lr, tmo, bg);
      tt = tt + tmo;
      @(negedge clk);
      n_cmp++;
      if (sd !== exp_frame(24'hC00003, 24'h3C3C3C)) begin
         n_bad++;
         $display("FAIL b2b_new_pair: got %h want %h", sd, exp_frame(24'hC00003, 24'h3C3C3C));
      end
      n_cmp++;
      if (ovf_cnt - o0 !== 0) begin
         n_bad++;
         $display("FAIL b2b_overflow: got %0d want 0", ovf_cnt - o0);
      end
      n_cmp++;
      if (und_cnt - u0 !== 0) begin
         n_bad++;
         $display("FAIL b2b_underrun: got %0d want 0", und_cnt - u0);
      end
      n_cmp++;
      if (tt !== 0) begin
         n_bad++;
         $display("FAIL b2b_timeout: got %0d want 0", tt);
      end
   endtask

   task automatic test_disable();
      int u0;
      restart();
      write(1'b1, 24'hFFFFFF);
      write(1'b0, 24'hFFFFFF);
      capture(1, 40, sd, lr, tmo, bg);
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata} !== 3'b111) begin
         n_bad++;
         $display("FAIL pre_disable_bit40: got %b want 111", {i2s_bclk, i2s_lrck, i2s_sdata});
      end
      tx_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow} !== 5'b0) begin
         n_bad++;
         $display("FAIL disable_idle: got %b want 00000", {i2s_bclk, i2s_lrck, i2s_sdata, underrun, overflow});
      end
      u0    = und_cnt;
      tx_en = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (i2s_bclk !== 1'b0) begin
         n_bad++;
         $display("FAIL reenable_bclk_clk1: got %b want 0", i2s_bclk);
      end
      write(1'b1, 24'h000100);
      n_cmp++;
      if (i2s_bclk !== 1'b1) begin
         n_bad++;
         $display("FAIL reenable_bclk_clk2: got %b want 1", i2s_bclk);
      end
      write(1'b0, 24'h800000);
      capture(1, 63, sd, lr, tmo, bg);
      @(negedge clk);
      n_cmp++;
      if (sd !== exp_frame(24'h000100, 24'h800000) || tmo !== 0) begin
         n_bad++;
         $display("FAIL reenable_frame: got %h want %h (timeouts %0d)", sd, exp_frame(24'h000100, 24'h800000), tmo);
      end
      n_cmp++;
      if (lr !== LRCK_EXP) begin
         n_bad++;
         $display("FAIL reenable_lrck: got %h want %h", lr, LRCK_EXP);
      end
      n_cmp++;
      if (und_cnt - u0 !== 0) begin
         n_bad++;
         $display("FAIL reenable_underrun: got %0d want 0", und_cnt - u0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      tx_en      = 1'b0;
      lrc        = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      test_reset();
      test_frame();
      test_underrun();
      test_overflow();
      test_back_to_back();
      test_disable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
